// File: rtl/wave_play_ctrl.sv
// Playback sequencer for the waveform RAM read port: turns (address, length)
// commands into consecutive read addresses plus a data-valid/last strobe pair.
module wave_play_ctrl #(
    parameter int DOUT_ADDR_WIDTH = 10,
    parameter int LEN_WIDTH       = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DOUT_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       stop,
    output logic [DOUT_ADDR_WIDTH-1:0] ram_read_addr,
    output logic                       data_valid,
    output logic                       data_last,
    output logic                       busy
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t                     state;
    logic [DOUT_ADDR_WIDTH-1:0] addr_cnt;
    logic [LEN_WIDTH-1:0]       remain;
    logic                       pend_valid;
    logic [DOUT_ADDR_WIDTH-1:0] pend_addr;
    logic [LEN_WIDTH-1:0]       pend_len;
    logic                       vld_p1;
    logic                       last_p1;

    logic accept;
    logic accept_nz;
    logic issue;
    logic last_issue;

    assign cmd_ready  = !pend_valid;
    assign accept     = cmd_valid & cmd_ready;
    // Zero-length commands complete the handshake but never load anything.
    assign accept_nz  = accept & (cmd_len != '0);
    assign issue      = (state == PLAY) & !stop;
    assign last_issue = issue & (remain == LEN_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            remain     <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_len   <= '0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
        end else begin
            // Stage p1: strobes delayed to line up with the RAM read latency.
            vld_p1  <= issue;
            last_p1 <= last_issue;

            if (stop) begin
                state      <= IDLE;
                pend_valid <= 1'b0;
            end else if (state == IDLE) begin
                if (accept_nz) begin
                    addr_cnt <= cmd_addr;
                    remain   <= cmd_len;
                    state    <= PLAY;
                end
            end else if (last_issue) begin
                // Hand over to the next command on the same edge: no bubble.
                if (pend_valid) begin
                    addr_cnt   <= pend_addr;
                    remain     <= pend_len;
                    pend_valid <= 1'b0;
                end else if (accept_nz) begin
                    addr_cnt <= cmd_addr;
                    remain   <= cmd_len;
                end else begin
                    addr_cnt <= addr_cnt + DOUT_ADDR_WIDTH'(1);
                    remain   <= '0;
                    state    <= IDLE;
                end
            end else begin
                addr_cnt <= addr_cnt + DOUT_ADDR_WIDTH'(1);
                remain   <= remain - LEN_WIDTH'(1);
                if (accept_nz) begin
                    pend_addr  <= cmd_addr;
                    pend_len   <= cmd_len;
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    assign ram_read_addr = addr_cnt;
    assign data_valid    = vld_p1;
    assign data_last     = last_p1;
    assign busy          = (state == PLAY);

endmodule

// File: tb/tb_wave_play_ctrl.sv
// Directed bench for wave_play_ctrl with a word-level scoreboard of
// expected (address, last) pairs checked against the delayed read strobes.
module tb_wave_play_ctrl;

    localparam int AW = 10;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          stop;
    logic [AW-1:0] ram_read_addr;
    logic          data_valid;
    logic          data_last;
    logic          busy;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
    } word_t;

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic [AW-1:0] prev_addr = '0;

    wave_play_ctrl #(.DOUT_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .stop         (stop),
        .ram_read_addr(ram_read_addr),
        .data_valid   (data_valid),
        .data_last    (data_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // The word shown with data_valid is the one addressed in the previous cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (data_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {21'd0, prev_addr, data_last}, 32'hFFFF_FFFF);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    chk("word_addr", 32'(prev_addr), 32'(e.addr));
                    chk("word_last", 32'(data_last), 32'(e.last));
                end
            end
        end
        prev_addr = ram_read_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [AW-1:0] a, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            word_t w;
            w.addr = a + AW'(i);
            w.last = with_last && (i == n - 1);
            exp_q.push_back(w);
        end
    endtask

    // Returns one time unit after the edge on which the handshake happened.
    task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l, input bit expect_words);
        bit ok;
        int n;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            ok = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        cmd_valid = 1'b0;
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
        else if (expect_words) push_words(a, int'(l), 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || data_valid || exp_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        chk(tag, 32'(exp_q.size()) + 32'(busy) + 32'(data_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_valid = 1'b0;
        stop      = 1'b0;
        #1;
        chk("rst_addr", 32'(ram_read_addr), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_last", 32'(data_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Single command (5,3)
        send(10'd5, 10'd3, 1'b1);
        chk("t1_addr0", 32'(ram_read_addr), 32'd5);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_dv0", 32'(data_valid), 32'd0);
        step();
        chk("t1_addr1", 32'(ram_read_addr), 32'd6);
        chk("t1_dv1", 32'(data_valid), 32'd1);
        step();
        chk("t1_addr2", 32'(ram_read_addr), 32'd7);
        chk("t1_last_early", 32'(data_last), 32'd0);
        step();
        chk("t1_dv3", 32'(data_valid), 32'd1);
        chk("t1_last", 32'(data_last), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        step();
        chk("t1_dv_end", 32'(data_valid), 32'd0);
        wait_idle("t1_idle");

        // Back-to-back (10,2) then (40,2)
        send(10'd10, 10'd2, 1'b1);
        send(10'd40, 10'd2, 1'b1);
        chk("t2_ready_low", 32'(cmd_ready), 32'd0);
        chk("t2_dv_a", 32'(data_valid), 32'd1);
        step();
        chk("t2_ready_high", 32'(cmd_ready), 32'd1);
        chk("t2_addr40", 32'(ram_read_addr), 32'd40);
        chk("t2_dv_b", 32'(data_valid), 32'd1);
        step();
        chk("t2_dv_c", 32'(data_valid), 32'd1);
        step();
        chk("t2_dv_d", 32'(data_valid), 32'd1);
        chk("t2_last", 32'(data_last), 32'd1);
        wait_idle("t2_idle");

        // Address wrap
        send(10'd1022, 10'd4, 1'b1);
        wait_idle("t3_idle");

        // Zero-length commands
        send(10'd7, 10'd0, 1'b0);
        chk("t4_busy", 32'(busy), 32'd0);
        step();
        chk("t4_dv", 32'(data_valid), 32'd0);
        send(10'd0, 10'd2, 1'b1);
        send(10'd7, 10'd0, 1'b0);
        wait_idle("t4_idle");

        // Stop with a pending command
        send(10'd100, 10'd8, 1'b0);
        push_words(10'd100, 3, 1'b0);
        send(10'd200, 10'd4, 1'b0);
        step();
        step();
        stop = 1'b1;
        chk("t5_dv_stop", 32'(data_valid), 32'd1);
        step();
        stop = 1'b0;
        chk("t5_dv_after", 32'(data_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(cmd_ready), 32'd1);
        step();
        chk("t5_dv_after2", 32'(data_valid), 32'd0);
        wait_idle("t5_idle");
        send(10'd300, 10'd1, 1'b1);
        wait_idle("t5_new_idle");

        // Reset mid-play
        send(10'd500, 10'd6, 1'b1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_dv", 32'(data_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_addr", 32'(ram_read_addr), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t6_ready", 32'(cmd_ready), 32'd1);
        chk("t6_dv_post", 32'(data_valid), 32'd0);
        send(10'd600, 10'd2, 1'b1);
        wait_idle("t6_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
